// File: rtl/joker_ep_in_buffer.sv
// joker_ep_in_buffer
// Ping-pong EP1 IN reply buffer between the Joker command controller and the
// USB device core. The controller fills one bank byte by byte and commits it
// with a length. The USB core reads the other bank and releases it with
// tx_done. Packets leave in commit order, and at most two are outstanding.
//
// Ports:
//   clk, reset          system clock, synchronous active-low reset
//   usb_in_addr/data    controller byte write into the current fill bank
//   usb_in_wren         write strobe, one byte per cycle
//   usb_in_commit       level commit request, acted on at its rising edge only
//   usb_in_commit_len   packet length, sampled at the commit edge
//   usb_in_commit_ack   acknowledge, high for ACK_CYCLES cycles per commit edge
//   usb_in_ready        fill bank is free (registered)
//   tx_valid, tx_len    packet available in the read bank, and its length
//   tx_rd_addr/data     read port into the read bank, 1-cycle latency
//   tx_done             pulse that releases the read bank
//   drop_count          dropped commits/writes, saturating (optional)
//
// Optional feature: define JOKER_EP_IN_DROP_CNT_EN to add drop_count.
module joker_ep_in_buffer #(
  parameter int ADDR_W     = 11,
  parameter int ACK_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] usb_in_addr,
  input  logic [7:0]        usb_in_data,
  input  logic              usb_in_wren,
  input  logic              usb_in_commit,
  input  logic [10:0]       usb_in_commit_len,
  output logic              usb_in_commit_ack,
  output logic              usb_in_ready,
  output logic              tx_valid,
  output logic [10:0]       tx_len,
  input  logic [ADDR_W-1:0] tx_rd_addr,
  output logic [7:0]        tx_rd_data,
  input  logic              tx_done
`ifdef JOKER_EP_IN_DROP_CNT_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  localparam logic [11:0] DEPTH_L = 12'(2**ADDR_W);

  // One bit of state per bank: 1 = FULL (owned by the read side), 0 = FREE.
  logic [1:0]       full_reg, full_next;
  logic [1:0][10:0] len_reg, len_next;
  logic             wr_bank_reg, wr_bank_next;
  logic             rd_bank_reg, rd_bank_next;
  logic             commit_prev_reg;
  logic [3:0]       ack_cnt_reg, ack_cnt_next;
  logic             ready_reg, ready_next;
  logic [7:0]       rd_data_reg;

  logic             commit_edge, ack_busy, commit_accept, commit_drop, done_accept;
  logic [10:0]      len_clamped;

  logic [7:0] mem [0:2**(ADDR_W+1)-1];

  // Next-state logic.
  assign commit_edge   = usb_in_commit & ~commit_prev_reg;
  assign ack_busy      = (ack_cnt_reg != 4'd0);
  // A new edge while the ack is still running is a drop, even if a bank is free.
  assign commit_accept = commit_edge & ~ack_busy & ~full_reg[wr_bank_reg];
  assign commit_drop   = commit_edge & ~commit_accept;
  assign done_accept   = tx_done & full_reg[rd_bank_reg];
  assign len_clamped   = ({1'b0, usb_in_commit_len} > DEPTH_L) ? DEPTH_L[10:0]
                                                               : usb_in_commit_len;

  // Accept and done can never target the same bank in one cycle. Accept needs
  // the fill bank FREE, and done needs the read bank FULL. Both decisions use
  // the pre-update state, so their updates are independent.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      assign full_next[gi] = (done_accept   && rd_bank_reg == 1'(gi)) ? 1'b0 :
                             (commit_accept && wr_bank_reg == 1'(gi)) ? 1'b1 :
                             full_reg[gi];
      assign len_next[gi]  = (commit_accept && wr_bank_reg == 1'(gi)) ? len_clamped
                                                                      : len_reg[gi];
    end
  endgenerate

  always_comb begin
    wr_bank_next = wr_bank_reg ^ commit_accept;
    rd_bank_next = rd_bank_reg ^ done_accept;
    ready_next   = ~full_reg[wr_bank_reg];
    ack_cnt_next = ack_cnt_reg;
    if (commit_edge)
      ack_cnt_next = 4'(ACK_CYCLES);
    else if (ack_busy)
      ack_cnt_next = ack_cnt_reg - 4'd1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full_reg        <= 2'b00;
      len_reg         <= '0;
      wr_bank_reg     <= 1'b0;
      rd_bank_reg     <= 1'b0;
      commit_prev_reg <= 1'b0;
      ack_cnt_reg     <= 4'd0;
      ready_reg       <= 1'b1;
    end else begin
      full_reg        <= full_next;
      len_reg         <= len_next;
      wr_bank_reg     <= wr_bank_next;
      rd_bank_reg     <= rd_bank_next;
      commit_prev_reg <= usb_in_commit;
      ack_cnt_reg     <= ack_cnt_next;
      ready_reg       <= ready_next;
    end
  end

  // Packet RAM. The two banks sit side by side and are selected by the top
  // address bit. The read is registered so the RAM maps onto block RAM.
  always_ff @(posedge clk) begin
    if (usb_in_wren && ready_reg)
      mem[{wr_bank_reg, usb_in_addr}] <= usb_in_data;
    rd_data_reg <= mem[{rd_bank_reg, tx_rd_addr}];
  end

  // Outputs.
  always_comb begin
    usb_in_commit_ack = ack_busy;
    usb_in_ready      = ready_reg;
    tx_valid          = full_reg[rd_bank_reg];
    tx_len            = len_reg[rd_bank_reg];
    tx_rd_data        = rd_data_reg;
  end

`ifdef JOKER_EP_IN_DROP_CNT_EN
  // Writes rejected while not ready count once per commit cycle. The sticky
  // flag suppresses further counts until the next commit edge.
  logic [15:0] drop_cnt_reg, drop_cnt_next;
  logic        wr_drop_flag_reg, wr_drop_flag_next;
  logic        wr_drop;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  always_comb begin
    wr_drop           = usb_in_wren & ~ready_reg & ~wr_drop_flag_reg;
    drop_inc          = {1'b0, commit_drop} + {1'b0, wr_drop};
    drop_sum          = {1'b0, drop_cnt_reg} + {15'd0, drop_inc};
    drop_cnt_next     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    wr_drop_flag_next = commit_edge ? 1'b0 : (wr_drop_flag_reg | wr_drop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt_reg     <= 16'd0;
      wr_drop_flag_reg <= 1'b0;
    end else begin
      drop_cnt_reg     <= drop_cnt_next;
      wr_drop_flag_reg <= wr_drop_flag_next;
    end
  end

  assign drop_count = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_joker_ep_in_buffer.sv
module tb_joker_ep_in_buffer;
  localparam int ADDR_W     = 10;
  localparam int ACK_CYCLES = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] usb_in_addr;
  logic [7:0]        usb_in_data;
  logic              usb_in_wren;
  logic              usb_in_commit;
  logic [10:0]       usb_in_commit_len;
  logic              usb_in_commit_ack;
  logic              usb_in_ready;
  logic              tx_valid;
  logic [10:0]       tx_len;
  logic [ADDR_W-1:0] tx_rd_addr;
  logic [7:0]        tx_rd_data;
  logic              tx_done;
`ifdef JOKER_EP_IN_DROP_CNT_EN
  logic [15:0]       drop_count;
`endif

  int checks = 0;
  int errors = 0;
  int n_ack;

  always #5 clk = ~clk;

  joker_ep_in_buffer #(.ADDR_W(ADDR_W), .ACK_CYCLES(ACK_CYCLES)) dut (
    .clk               (clk),
    .reset             (reset),
    .usb_in_addr       (usb_in_addr),
    .usb_in_data       (usb_in_data),
    .usb_in_wren       (usb_in_wren),
    .usb_in_commit     (usb_in_commit),
    .usb_in_commit_len (usb_in_commit_len),
    .usb_in_commit_ack (usb_in_commit_ack),
    .usb_in_ready      (usb_in_ready),
    .tx_valid          (tx_valid),
    .tx_len            (tx_len),
    .tx_rd_addr        (tx_rd_addr),
    .tx_rd_data        (tx_rd_data),
    .tx_done           (tx_done)
`ifdef JOKER_EP_IN_DROP_CNT_EN
    ,
    .drop_count        (drop_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    usb_in_addr = a;
    usb_in_data = d;
    usb_in_wren = 1'b1;
    tick();
    usb_in_wren = 1'b0;
  endtask

  // Raise commit, count the ack-high cycles (bounded), then drop commit.
  task automatic do_commit(input logic [10:0] len, output int acks);
    usb_in_commit_len = len;
    usb_in_commit     = 1'b1;
    tick();
    acks = 0;
    while (usb_in_commit_ack && acks < 20) begin
      acks++;
      tick();
    end
    usb_in_commit = 1'b0;
    tick();
  endtask

  task automatic read_byte(input logic [ADDR_W-1:0] a, input string tag, input logic [7:0] exp);
    tx_rd_addr = a;
    tick();
    check(tag, tx_rd_data, exp);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    usb_in_addr = '0;
    usb_in_data = 8'h00;
    usb_in_wren = 1'b0;
    usb_in_commit = 1'b0;
    usb_in_commit_len = 11'd0;
    tx_rd_addr = '0;
    tx_done = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_ack", usb_in_commit_ack, 1'b0);
    check("rst_ready", usb_in_ready, 1'b1);
    check("rst_valid", tx_valid, 1'b0);
    check("rst_len", tx_len, 11'd0);
`ifdef JOKER_EP_IN_DROP_CNT_EN
    check("rst_drop", drop_count, 16'd0);
`endif
    reset = 1'b1;
    tick();

    // Single packet: bank0.
    write_byte(10'd0, 8'h09);
    write_byte(10'd1, 8'h5A);
    do_commit(11'd2, n_ack);
    check("p1_ack_cycles", n_ack, ACK_CYCLES);
    check("p1_valid", tx_valid, 1'b1);
    check("p1_len", tx_len, 11'd2);
    read_byte(10'd0, "p1_rd0", 8'h09);
    read_byte(10'd1, "p1_rd1", 8'h5A);
    pulse_done();
    check("p1_done_valid", tx_valid, 1'b0);
    check("p1_done_ready", usb_in_ready, 1'b1);

    // Two back-to-back packets: A goes into bank1, B goes into bank0.
    write_byte(10'd0, 8'h11);
    write_byte(10'd1, 8'h22);
    do_commit(11'd2, n_ack);
    check("pa_ready", usb_in_ready, 1'b1);
    for (int i = 0; i < 7; i++) write_byte(10'(i), 8'(8'h30 + i));
    do_commit(11'd7, n_ack);
    check("pb_ready", usb_in_ready, 1'b0);
    check("pb_valid", tx_valid, 1'b1);
    check("pb_head_len", tx_len, 11'd2);

    // Third commit while both banks are FULL: it is acked and dropped.
    do_commit(11'd5, n_ack);
    check("drop_ack_cycles", n_ack, ACK_CYCLES);
    check("drop_len_kept", tx_len, 11'd2);
`ifdef JOKER_EP_IN_DROP_CNT_EN
    check("drop_cnt1", drop_count, 16'd1);
`endif
    // Writes while not ready are discarded. Only the first one is counted.
    write_byte(10'd0, 8'hEE);
    write_byte(10'd1, 8'hEF);
`ifdef JOKER_EP_IN_DROP_CNT_EN
    check("drop_cnt2", drop_count, 16'd2);
`endif
    read_byte(10'd0, "pa_rd0", 8'h11);
    read_byte(10'd1, "pa_rd1", 8'h22);
    pulse_done();
    check("pb_valid2", tx_valid, 1'b1);
    check("pb_len", tx_len, 11'd7);
    tick();
    check("pb_ready_back", usb_in_ready, 1'b1);
    read_byte(10'd0, "pb_rd0", 8'h30);
    read_byte(10'd6, "pb_rd6", 8'h36);
    pulse_done();
    check("pb_done_valid", tx_valid, 1'b0);

    // Commit held high for 20 cycles gives exactly one ack pulse.
    write_byte(10'd0, 8'h77);
    usb_in_commit_len = 11'd3;
    usb_in_commit = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (usb_in_commit_ack) n_ack++;
    end
    usb_in_commit = 1'b0;
    repeat (2) tick();
    check("hold_ack_cycles", n_ack, ACK_CYCLES);
    check("hold_valid", tx_valid, 1'b1);
    check("hold_len", tx_len, 11'd3);
    read_byte(10'd0, "hold_rd0", 8'h77);
`ifdef JOKER_EP_IN_DROP_CNT_EN
    check("hold_drop", drop_count, 16'd2);
`endif
    pulse_done();
    check("hold_done_valid", tx_valid, 1'b0);

    // Zero-length packet, then a length larger than a bank.
    do_commit(11'd0, n_ack);
    check("zlp_valid", tx_valid, 1'b1);
    check("zlp_len", tx_len, 11'd0);
    pulse_done();
    do_commit(11'd2047, n_ack);
    check("clamp_len", tx_len, 11'd1024);
    pulse_done();
    check("clamp_done_valid", tx_valid, 1'b0);

    // Reset in the middle of an ack while one bank is FULL.
    usb_in_commit_len = 11'd5;
    usb_in_commit = 1'b1;
    tick();
    tick();
    check("mid_ack_high", usb_in_commit_ack, 1'b1);
    check("mid_valid", tx_valid, 1'b1);
    reset = 1'b0;
    usb_in_commit = 1'b0;
    tick();
    check("mid_rst_ack", usb_in_commit_ack, 1'b0);
    check("mid_rst_valid", tx_valid, 1'b0);
    check("mid_rst_ready", usb_in_ready, 1'b1);
    check("mid_rst_len", tx_len, 11'd0);
`ifdef JOKER_EP_IN_DROP_CNT_EN
    check("mid_rst_drop", drop_count, 16'd0);
`endif
    reset = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/joker_ep_in_buffer.md
Name: joker_ep_in_buffer

Overview:
- Double-buffered (ping-pong) EP1 IN reply buffer that sits directly downstream of the Joker command controller.
- Accepts byte writes plus a length-qualified commit request from the controller and returns the commit acknowledge and buffer-ready status it expects.
- Presents each committed reply packet to the USB device core through a read-port/done handshake.

Parameters:
- ADDR_W, 11, byte address width of one bank; bank depth is 2**ADDR_W bytes.
- ACK_CYCLES, 4, number of cycles usb_in_commit_ack is held high per commit (legal range 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- usb_in_addr  in  ADDR_W  controller write byte address within the current fill bank
- usb_in_data  in  8  controller write data
- usb_in_wren  in  1  write enable, one byte per cycle while high
- usb_in_commit  in  1  level commit request; controller drops it after seeing ack fall
- usb_in_commit_len  in  11  packet length sampled at commit edge
- usb_in_commit_ack  out  1  commit acknowledge pulse, ACK_CYCLES long
- usb_in_ready  out  1  high when the current fill bank is free to be written
- tx_valid  out  1  a committed packet is available in the read bank
- tx_len  out  11  length of the packet in the read bank
- tx_rd_addr  in  ADDR_W  USB core read address within the read bank
- tx_rd_data  out  8  read data, 1-cycle latency from tx_rd_addr
- tx_done  in  1  single-cycle pulse: read bank fully sent, release it
- drop_count  out  16  present only with the optional feature

Behaviour:
- Reset (reset==0 at clk edge):
  - both banks FREE; wr_bank=0, rd_bank=0
  - usb_in_commit_ack=0, usb_in_ready=1, tx_valid=0, tx_len=0, drop_count=0
  - commit_prev=0; RAM contents undefined
  - a reset mid-transfer discards all stored packets and any in-progress ack
- Per-bank state: FREE -> FULL on commit, FULL -> FREE on tx_done. The read side owns a bank only while it is FULL and equal to rd_bank.
- usb_in_ready = (state[wr_bank]==FREE), registered, so it updates 1 cycle after the state change.
- Writes:
  - while wren=1 and usb_in_ready=1, RAM[{wr_bank,usb_in_addr}] <= usb_in_data
  - while usb_in_ready=0, writes are ignored (discarded)
- Commit detection on the rising edge only (usb_in_commit & ~commit_prev):
  - If state[wr_bank]==FREE:
    - latch len = min(usb_in_commit_len, 2**ADDR_W) into len[wr_bank]
    - state[wr_bank] <= FULL; wr_bank toggles
  - If not FREE: packet dropped, drop_count increments (saturating at 16'hFFFF).
  - In both cases the ack sequence starts the cycle after the edge: usb_in_commit_ack=1 for exactly ACK_CYCLES cycles, then 0.
  - A held-high commit never retriggers.
  - A new rising edge while ack is still high is treated as a drop, and the ack counter restarts.
- Length 0 commit is legal (zero-length packet): tx_valid=1, tx_len=0.
- Read side:
  - tx_valid = (state[rd_bank]==FULL); tx_len = len[rd_bank]
  - tx_rd_data = RAM[{rd_bank,tx_rd_addr}], registered
- tx_done with tx_valid=1: state[rd_bank] <= FREE and rd_bank toggles next cycle. tx_done with tx_valid=0 is ignored.
- Commit edge and tx_done in the same cycle: both applied.
  - If the done frees the bank that wr_bank points at, the commit still sees the pre-update state and is dropped.
  - The controller never commits without ready, so this is a protocol-violation path only.
- Ordering: packets are delivered strictly in commit order; at most 2 outstanding.

Optional Feature:
- Macro: JOKER_EP_IN_DROP_CNT_EN.
- Defined: drop_count port exists and behaves as above. A write with usb_in_ready=0 also increments drop_count, at most once per commit cycle (sticky flag cleared at the next commit edge).
- Undefined: drop_count port and counter are absent. Drops are silent but still acknowledged.

Test Plan:
- Write 0x09 at addr0 and 0x5A at addr1, commit len=2 -> ack high 4 cycles, tx_valid=1, tx_len=2; read addr0/1 -> 0x09/0x5A one cycle later; tx_done -> tx_valid=0, ready=1.
- Two back-to-back commits (len 2 and len 7) without tx_done -> ready=0 after second; packets read out in order with lengths 2 then 7.
- Third commit while both banks FULL -> ack still pulses 4 cycles, drop_count=1, first two packets intact.
- Commit held high for 20 cycles -> exactly one ack pulse, one packet stored.
- Commit len=0 -> tx_valid=1, tx_len=0; commit len=2047 with ADDR_W=10 -> tx_len=1024.
- Assert reset low mid-ack with one bank FULL -> next cycle ack=0, tx_valid=0, ready=1, drop_count=0.
